// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the command master FSM state type.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RSP  = 2'b11
    } state_e;

endpackage

// File: rtl/ahb_lite_cmd_master.sv
// Command/response to single-transfer AHB-Lite initiator, one transfer in flight.
// Define AHB_LITE_CMD_MASTER_ALIGN_CHECK_EN to reject misaligned commands instead of clearing low address bits.
module ahb_lite_cmd_master
    import ahb_lite_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic              HCLK,
    input  logic              HRESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP
);

    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > HSIZE_WORD) ? HSIZE_WORD : size;
    endfunction

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr,
                                                     input logic [2:0] size);
        logic [ADDR_W-1:0] a;
        a = addr;
        case (size)
            HSIZE_HALF: a[0]   = 1'b0;
            HSIZE_WORD: a[1:0] = 2'b00;
            default:    a      = addr;
        endcase
        return a;
    endfunction

`ifdef AHB_LITE_CMD_MASTER_ALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr,
                                           input logic [2:0] size);
        logic m;
        case (size)
            HSIZE_HALF: m = addr[0];
            HSIZE_WORD: m = |addr[1:0];
            default:    m = 1'b0;
        endcase
        return m;
    endfunction
`endif

    state_e              state_r, state_nxt_s;
    logic                cmd_ready_r, cmd_ready_nxt_s;
    logic [1:0]          htrans_r, htrans_nxt_s;
    logic [ADDR_W-1:0]   haddr_r, haddr_nxt_s;
    logic                hwrite_r, hwrite_nxt_s;
    logic [2:0]          hsize_r, hsize_nxt_s;
    logic [DATA_W-1:0]   hwdata_r, hwdata_nxt_s;
    logic                rsp_valid_r, rsp_valid_nxt_s;
    logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_nxt_s;
    logic                rsp_err_r, rsp_err_nxt_s;
    logic [2:0]          size_s;
    logic                reject_s;
    logic                bus_err_s;

    assign size_s    = clamp_size(cmd_size);
    assign bus_err_s = (HRESP == HRESP_ERROR);
`ifdef AHB_LITE_CMD_MASTER_ALIGN_CHECK_EN
    assign reject_s  = is_misaligned(cmd_addr, size_s);
`else
    assign reject_s  = 1'b0;
`endif

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        state_nxt_s     = state_r;
        cmd_ready_nxt_s = 1'b0;
        htrans_nxt_s    = HTRANS_IDLE;
        haddr_nxt_s     = haddr_r;
        hwrite_nxt_s    = hwrite_r;
        hsize_nxt_s     = hsize_r;
        hwdata_nxt_s    = hwdata_r;
        rsp_valid_nxt_s = 1'b0;
        rsp_rdata_nxt_s = rsp_rdata_r;
        rsp_err_nxt_s   = rsp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    if (reject_s) begin
                        state_nxt_s     = ST_RSP;
                        rsp_valid_nxt_s = 1'b1;
                        rsp_rdata_nxt_s = {DATA_W{1'b0}};
                        rsp_err_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s     = ST_ADDR;
                        htrans_nxt_s    = HTRANS_NONSEQ;
                        haddr_nxt_s     = align_addr(cmd_addr, size_s);
                        hwrite_nxt_s    = cmd_write;
                        hsize_nxt_s     = size_s;
                        hwdata_nxt_s    = cmd_write ? cmd_wdata : {DATA_W{1'b0}};
                    end
                end else begin
                    cmd_ready_nxt_s = 1'b1;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_nxt_s  = ST_DATA;
                end else begin
                    htrans_nxt_s = HTRANS_NONSEQ;
                end
            end
            ST_DATA: begin
                // Read data is discarded on error since the slave need not drive it.
                if (HREADY) begin
                    state_nxt_s     = ST_RSP;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_err_nxt_s   = bus_err_s;
                    rsp_rdata_nxt_s = (!hwrite_r && !bus_err_s) ? HRDATA : {DATA_W{1'b0}};
                end else begin
                    state_nxt_s     = ST_DATA;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_nxt_s     = ST_IDLE;
                    cmd_ready_nxt_s = 1'b1;
                end else begin
                    rsp_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            htrans_r    <= HTRANS_IDLE;
            haddr_r     <= {ADDR_W{1'b0}};
            hwrite_r    <= 1'b0;
            hsize_r     <= HSIZE_BYTE;
            hwdata_r    <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= cmd_ready_nxt_s;
            htrans_r    <= htrans_nxt_s;
            haddr_r     <= haddr_nxt_s;
            hwrite_r    <= hwrite_nxt_s;
            hsize_r     <= hsize_nxt_s;
            hwdata_r    <= hwdata_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign HADDR     = haddr_r;
    assign HTRANS    = htrans_r;
    assign HWRITE    = hwrite_r;
    assign HSIZE     = hsize_r;
    assign HWDATA    = hwdata_r;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

endmodule
